// File: rtl/zone_scanner.sv
// zone_scanner: walks a 16:1 sensor mux through zones 0..15. It holds each
// select value for SETTLE_CYCLES cycles and then samples the mux output for
// one cycle. Every zone has its own debounce counter. The first zone to
// reach DEBOUNCE sets a sticky alarm and records its index.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   arm         level; 1 = scanning, 0 = idle (counters and select cleared)
//   clear       single-cycle pulse; clears alarm and alarm_zone
//   zone_mask   per-zone enable; a masked zone never counts
//   mux_in      mux output for the currently selected zone
//   sel         zone select driven to the mux
//   zone_status per-zone flag, set while that zone's counter equals DEBOUNCE
//   alarm       sticky alarm flag
//   alarm_zone  index of the zone that set alarm
//   scan_done   high for one cycle, during the SAMPLE cycle of zone 15
module zone_scanner #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DEBOUNCE      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        clear,
  input  logic [15:0] zone_mask,
  input  logic        mux_in,
  output logic [3:0]  sel,
  output logic [15:0] zone_status,
  output logic        alarm,
  output logic [3:0]  alarm_zone,
  output logic        scan_done
);

  localparam int unsigned ZONES = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SET_W = 8;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] ZONE_LAST = SEL_W'(ZONES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  state_t                       r_state;
  logic [SET_W-1:0]             r_settle;
  logic [SEL_W-1:0]             r_sel;
  logic [ZONES-1:0][CNT_W-1:0]  r_cnt;
  logic [ZONES-1:0]             r_zone_status;
  logic                         r_alarm;
  logic [SEL_W-1:0]             r_alarm_zone;
  logic                         r_scan_done;

  logic                         w_hit;
  logic [CNT_W-1:0]             w_cur_cnt;
  logic [CNT_W-1:0]             w_next_cnt;
  logic                         w_trip;
  logic                         w_set;

  // Next debounce count for the zone currently being sampled.
  always_comb begin
    w_hit      = mux_in & zone_mask[r_sel];
    w_cur_cnt  = r_cnt[r_sel];
    w_next_cnt = '0;
    if (w_hit) begin
      w_next_cnt = (w_cur_cnt == CNT_MAX) ? w_cur_cnt : w_cur_cnt + CNT_W'(1);
    end
    w_trip = (w_next_cnt == CNT_MAX);
    w_set  = arm && (r_state == ST_SAMPLE) && w_trip && !r_alarm;
  end

  // Scan sequencer, debounce counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_settle      <= '0;
      r_sel         <= '0;
      r_cnt         <= '0;
      r_zone_status <= '0;
      r_scan_done   <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      if (!arm) begin
        // Disarm from any state drops all scan progress.
        r_state       <= ST_IDLE;
        r_settle      <= '0;
        r_sel         <= '0;
        r_cnt         <= '0;
        r_zone_status <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_SETTLE;
            r_settle <= '0;
          end
          ST_SETTLE: begin
            if (r_settle == SET_LAST) begin
              r_state     <= ST_SAMPLE;
              // Registered so the pulse lines up with zone 15's SAMPLE cycle.
              r_scan_done <= (r_sel == ZONE_LAST);
            end else begin
              r_settle <= r_settle + SET_W'(1);
            end
          end
          ST_SAMPLE: begin
            r_cnt[r_sel]         <= w_next_cnt;
            r_zone_status[r_sel] <= w_trip;
            r_sel                <= r_sel + SEL_W'(1);
            r_settle             <= '0;
            r_state              <= ST_SETTLE;
          end
          default: begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_sel    <= '0;
          end
        endcase
      end
    end
  end

  // Sticky alarm. The first zone to trip wins, and clear beats a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm      <= 1'b0;
      r_alarm_zone <= '0;
    end else if (clear) begin
      r_alarm      <= 1'b0;
      r_alarm_zone <= '0;
    end else if (w_set) begin
      r_alarm      <= 1'b1;
      r_alarm_zone <= r_sel;
    end
  end

  assign sel         = r_sel;
  assign zone_status = r_zone_status;
  assign alarm       = r_alarm;
  assign alarm_zone  = r_alarm_zone;
  assign scan_done   = r_scan_done;

endmodule

// File: tb/tb_zone_scanner.sv
// Directed testbench for zone_scanner at default parameters.
// The bench holds a 16-bit trip pattern and acts as the sensor mux for it.
// Cycle n is the negedge that follows the n-th rising edge after arm goes
// high. At the defaults, zone z is sampled for sweep s on edge 6+5z+80s.
module tb_zone_scanner;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        clear;
  logic [15:0] zone_mask;
  logic        mux_in;
  logic [3:0]  sel;
  logic [15:0] zone_status;
  logic        alarm;
  logic [3:0]  alarm_zone;
  logic        scan_done;

  logic [15:0] trip;
  int          cyc_n;
  int          checks;
  int          failures;

  zone_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .clear      (clear),
    .zone_mask  (zone_mask),
    .mux_in     (mux_in),
    .sel        (sel),
    .zone_status(zone_status),
    .alarm      (alarm),
    .alarm_zone (alarm_zone),
    .scan_done  (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor mux: the tripped pattern is routed by the select lines.
  assign mux_in = trip[sel];

  task automatic do_reset();
    arm       = 1'b0;
    clear     = 1'b0;
    trip      = 16'h0000;
    zone_mask = 16'hFFFF;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm_now();
    arm   = 1'b1;
    cyc_n = 0;
  endtask

  task automatic wait_to(input int c);
    while (cyc_n < c) begin
      @(negedge clk);
      cyc_n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({sel, zone_status, alarm, alarm_zone, scan_done} !== 26'd0) begin
      failures++;
      $display("FAIL reset_idle: sel=%0d status=%h alarm=%b zone=%0d done=%b, required all 0",
               sel, zone_status, alarm, alarm_zone, scan_done);
    end
    arm_now();
    wait_to(37);
    checks++;
    if (sel !== 4'd7) begin
      failures++; $display("FAIL reset_pre_sel: sel=%0d required 7", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, zone_status, alarm, alarm_zone, scan_done} !== 26'd0) begin
      failures++;
      $display("FAIL reset_async: sel=%0d status=%h alarm=%b zone=%0d done=%b, required all 0",
               sel, zone_status, alarm, alarm_zone, scan_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc_n = 0;
    wait_to(5);
    checks++;
    if (sel !== 4'd0) begin
      failures++; $display("FAIL reset_restart_c5: sel=%0d required 0", sel);
    end
    wait_to(6);
    checks++;
    if (sel !== 4'd1) begin
      failures++; $display("FAIL reset_restart_c6: sel=%0d required 1", sel);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    arm_now();
    for (int c = 1; c <= 170; c++) begin
      wait_to(c);
      checks++;
      if (sel !== 4'(((c - 1) / 5) % 16)) begin
        failures++;
        $display("FAIL sweep_sel c=%0d: sel=%0d required %0d", c, sel, ((c - 1) / 5) % 16);
      end
      checks++;
      if (scan_done !== ((c == 80) || (c == 160))) begin
        failures++;
        $display("FAIL sweep_done c=%0d: scan_done=%b required %b", c, scan_done,
                 (c == 80) || (c == 160));
      end
    end
    checks++;
    if (alarm !== 1'b0 || zone_status !== 16'h0000) begin
      failures++;
      $display("FAIL sweep_quiet: alarm=%b status=%h required 0/0000", alarm, zone_status);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    trip = 16'h0020;
    arm_now();
    wait_to(111);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL deb_2nd: status=%h alarm=%b required 0000/0", zone_status, alarm);
    end
    wait_to(190);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL deb_pre3: status=%h alarm=%b required 0000/0", zone_status, alarm);
    end
    wait_to(191);
    checks++;
    if (zone_status !== 16'h0020 || alarm !== 1'b1 || alarm_zone !== 4'd5) begin
      failures++;
      $display("FAIL deb_3rd: status=%h alarm=%b zone=%0d required 0020/1/5",
               zone_status, alarm, alarm_zone);
    end
    wait_to(192);
    trip = 16'h0000;
    wait_to(271);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL deb_drop: status=%h alarm=%b required 0000/1", zone_status, alarm);
    end
    wait_to(272);
    clear = 1'b1;
    wait_to(273);
    clear = 1'b0;
    trip  = 16'h0020;
    checks++;
    if (alarm !== 1'b0 || alarm_zone !== 4'd0) begin
      failures++;
      $display("FAIL deb_clear: alarm=%b zone=%0d required 0/0", alarm, alarm_zone);
    end
    wait_to(510);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL deb_re_pre3: status=%h alarm=%b required 0000/0", zone_status, alarm);
    end
    wait_to(511);
    checks++;
    if (zone_status !== 16'h0020 || alarm !== 1'b1 || alarm_zone !== 4'd5) begin
      failures++;
      $display("FAIL deb_re_3rd: status=%h alarm=%b zone=%0d required 0020/1/5",
               zone_status, alarm, alarm_zone);
    end
  endtask

  task automatic test_priority();
    do_reset();
    trip = 16'h0204;
    arm_now();
    wait_to(176);
    checks++;
    if (alarm !== 1'b1 || alarm_zone !== 4'd2) begin
      failures++;
      $display("FAIL prio_first: alarm=%b zone=%0d required 1/2", alarm, alarm_zone);
    end
    wait_to(211);
    checks++;
    if (zone_status !== 16'h0204 || alarm_zone !== 4'd2) begin
      failures++;
      $display("FAIL prio_keep: status=%h zone=%0d required 0204/2", zone_status, alarm_zone);
    end
    wait_to(215);
    clear = 1'b1;
    wait_to(216);
    clear = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL prio_clear: alarm=%b required 0", alarm);
    end
    wait_to(255);
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL prio_pre_reset: alarm=%b required 0", alarm);
    end
    wait_to(256);
    checks++;
    if (alarm !== 1'b1 || alarm_zone !== 4'd2) begin
      failures++;
      $display("FAIL prio_reassert: alarm=%b zone=%0d required 1/2", alarm, alarm_zone);
    end
    wait_to(260);
    clear = 1'b1;
    wait_to(261);
    clear = 1'b0;
    wait_to(290);
    clear = 1'b1;
    wait_to(291);
    clear = 1'b0;
    checks++;
    if (alarm !== 1'b0 || alarm_zone !== 4'd0) begin
      failures++;
      $display("FAIL prio_clear_wins: alarm=%b zone=%0d required 0/0", alarm, alarm_zone);
    end
    wait_to(336);
    checks++;
    if (alarm !== 1'b1 || alarm_zone !== 4'd2) begin
      failures++;
      $display("FAIL prio_after_coincident: alarm=%b zone=%0d required 1/2", alarm, alarm_zone);
    end
  endtask

  task automatic test_mask();
    do_reset();
    zone_mask = 16'hFF7F;
    trip      = 16'h0080;
    arm_now();
    wait_to(201);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL mask_off: status=%h alarm=%b required 0000/0", zone_status, alarm);
    end
    wait_to(205);
    zone_mask = 16'hFFFF;
    wait_to(440);
    checks++;
    if (zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL mask_pre3: status=%h alarm=%b required 0000/0", zone_status, alarm);
    end
    wait_to(441);
    checks++;
    if (zone_status !== 16'h0080 || alarm !== 1'b1 || alarm_zone !== 4'd7) begin
      failures++;
      $display("FAIL mask_on: status=%h alarm=%b zone=%0d required 0080/1/7",
               zone_status, alarm, alarm_zone);
    end
  endtask

  task automatic test_disarm();
    do_reset();
    trip = 16'h0020;
    arm_now();
    wait_to(218);
    checks++;
    if (sel !== 4'd11 || zone_status !== 16'h0020 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL disarm_pre: sel=%0d status=%h alarm=%b required 11/0020/1",
               sel, zone_status, alarm);
    end
    arm = 1'b0;
    wait_to(219);
    checks++;
    if (sel !== 4'd0 || zone_status !== 16'h0000 || alarm !== 1'b1 || alarm_zone !== 4'd5) begin
      failures++;
      $display("FAIL disarm_now: sel=%0d status=%h alarm=%b zone=%0d required 0/0000/1/5",
               sel, zone_status, alarm, alarm_zone);
    end
    wait_to(230);
    checks++;
    if (sel !== 4'd0 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL disarm_idle: sel=%0d alarm=%b required 0/1", sel, alarm);
    end
    clear = 1'b1;
    wait_to(231);
    clear = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      failures++; $display("FAIL disarm_clear: alarm=%b required 0", alarm);
    end
    arm_now();
    wait_to(31);
    checks++;
    if (sel !== 4'd6 || zone_status !== 16'h0000 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL rearm_clean: sel=%0d status=%h alarm=%b required 6/0000/0",
               sel, zone_status, alarm);
    end
    wait_to(191);
    checks++;
    if (zone_status !== 16'h0020 || alarm !== 1'b1 || alarm_zone !== 4'd5) begin
      failures++;
      $display("FAIL rearm_trip: status=%h alarm=%b zone=%0d required 0020/1/5",
               zone_status, alarm, alarm_zone);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc_n     = 0;
    rst_n     = 1'b0;
    arm       = 1'b0;
    clear     = 1'b0;
    trip      = 16'h0000;
    zone_mask = 16'hFFFF;
    test_reset();
    test_sweep();
    test_debounce();
    test_priority();
    test_mask();
    test_disarm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
